// File: rtl/snn_pkg.sv
// Shared fixed-point definitions for the spiking network blocks.
// Q3.20 signed values (3 integer bits including sign, 20 fraction bits).
package snn_pkg;

  localparam int unsigned FIX_I = 3;
  localparam int unsigned FIX_F = 20;
  localparam int unsigned FIX_N = FIX_I + FIX_F;

  typedef logic signed [FIX_N-1:0] fix_t;

  localparam fix_t FIX_MAX = 23'sh3F_FFFF;
  localparam fix_t FIX_MIN = 23'sh40_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } syn_state_t;

endpackage

// File: rtl/spike_syn_decoder_sat_add.sv
// sat_add: combinational signed Q3.20 add with clamp to FIX_MIN/FIX_MAX.
// ovf flags any result that had to be clamped. Shared with the neuron blocks.
module sat_add
  import snn_pkg::*;
(
  input  logic signed [FIX_N-1:0] a,
  input  logic signed [FIX_N-1:0] b,
  output logic signed [FIX_N-1:0] sum,
  output logic                    ovf
);

  localparam logic signed [FIX_N:0] WIDE_MAX = {1'b0, FIX_MAX};
  localparam logic signed [FIX_N:0] WIDE_MIN = {1'b1, FIX_MIN};

  logic signed [FIX_N:0] wide;

  // One extra bit of headroom, then clamp back into the Q3.20 range.
  always_comb begin
    wide = {a[FIX_N-1], a} + {b[FIX_N-1], b};
    ovf  = 1'b0;
    sum  = wide[FIX_N-1:0];
    if (wide > WIDE_MAX) begin
      sum = FIX_MAX;
      ovf = 1'b1;
    end else if (wide < WIDE_MIN) begin
      sum = FIX_MIN;
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/spike_syn_decoder.sv
// spike_syn_decoder: turns a 1-bit spike train into a decaying Q3.20
// synaptic current for the next neuron layer.
// Optional windowed spike-rate counter enabled by defining SYN_RATE_EN;
// without it rate_count and rate_valid are tied to 0.
module spike_syn_decoder
  import snn_pkg::*;
#(
  parameter logic signed [22:0] W_SYN   = 23'sh0_2000_0,
  parameter int unsigned        TAU_SH  = 4,
  parameter int unsigned        WIN_LEN = 256,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    spike_in,
  output logic signed [FIX_N-1:0] I_out,
  output logic                    sat,
  output logic [CNT_W-1:0]        rate_count,
  output logic                    rate_valid
);

  if (WIN_LEN < 2) begin : g_win_len_check
    $error("spike_syn_decoder: WIN_LEN must be at least 2");
  end

  syn_state_t state;
  logic       run;
  fix_t       decayed;
  fix_t       addend;
  fix_t       sum;
  logic       ovf;

  // Updates happen on edges where the FSM is already in RUN, so the
  // IDLE->RUN edge does not touch I_out while the RUN->IDLE edge does.
  assign run     = (state == RUN);
  assign decayed = I_out - (I_out >>> TAU_SH);
  assign addend  = spike_in ? W_SYN : '0;

  sat_add u_sat_add (
    .a   (decayed),
    .b   (addend),
    .sum (sum),
    .ovf (ovf)
  );

  // FSM: RUN follows en; reset forces IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= en ? RUN : IDLE;
    end
  end

  // Leaky current integrator; I_out and sat hold while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      I_out <= '0;
      sat   <= 1'b0;
    end else if (run) begin
      I_out <= sum;
      sat   <= ovf;
    end
  end

`ifdef SYN_RATE_EN
  localparam int unsigned WIN_W = $clog2(WIN_LEN);

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] spk_next;
  logic             win_end;

  assign win_end = (win_cnt == WIN_W'(WIN_LEN - 1));

  // Saturating spike count including this cycle's spike.
  always_comb begin
    spk_next = spk_cnt;
    if (spike_in && (spk_cnt != '1)) begin
      spk_next = spk_cnt + 1'b1;
    end
  end

  // Window sequencer: publishes the count at the terminal cycle; idle discards the partial window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt    <= '0;
      spk_cnt    <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
    end else begin
      rate_valid <= 1'b0;
      if (!run) begin
        win_cnt <= '0;
        spk_cnt <= '0;
      end else if (win_end) begin
        rate_count <= spk_next;
        rate_valid <= 1'b1;
        win_cnt    <= '0;
        spk_cnt    <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        spk_cnt <= spk_next;
      end
    end
  end
`else
  assign rate_count = '0;
  assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_syn_decoder.sv
// Directed self-checking bench for spike_syn_decoder. Expected rate results
// follow SYN_RATE_EN so the same bench covers both builds.
module tb_spike_syn_decoder;
  import snn_pkg::*;

  localparam fix_t W_DEF = 23'sh02_0000;
  localparam fix_t W_BIG = 23'sh20_0000;
`ifdef SYN_RATE_EN
  localparam bit RATE_ON = 1'b1;
`else
  localparam bit RATE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_d = 1'b0, spk_d = 1'b0;
  logic en_s = 1'b0, spk_s = 1'b0;
  logic en_r = 1'b0, spk_r = 1'b0;
  logic en_l = 1'b0, spk_l = 1'b0;

  fix_t i_d, i_s, i_r, i_l;
  logic sat_d, sat_s, sat_r, sat_l;
  logic [7:0] rc_d, rc_s, rc_r, rc_l;
  logic rv_d, rv_s, rv_r, rv_l;

  int vectors = 0;
  int miscompares = 0;
  fix_t exp_r;

  always #5 clk = ~clk;

  spike_syn_decoder u_def (
    .clk(clk), .rst(rst), .en(en_d), .spike_in(spk_d),
    .I_out(i_d), .sat(sat_d), .rate_count(rc_d), .rate_valid(rv_d)
  );

  spike_syn_decoder #(.W_SYN(W_BIG)) u_sat (
    .clk(clk), .rst(rst), .en(en_s), .spike_in(spk_s),
    .I_out(i_s), .sat(sat_s), .rate_count(rc_s), .rate_valid(rv_s)
  );

  spike_syn_decoder #(.WIN_LEN(16), .CNT_W(8)) u_rate (
    .clk(clk), .rst(rst), .en(en_r), .spike_in(spk_r),
    .I_out(i_r), .sat(sat_r), .rate_count(rc_r), .rate_valid(rv_r)
  );

  spike_syn_decoder #(.WIN_LEN(320), .CNT_W(8)) u_long (
    .clk(clk), .rst(rst), .en(en_l), .spike_in(spk_l),
    .I_out(i_l), .sat(sat_l), .rate_count(rc_l), .rate_valid(rv_l)
  );

  // Reference current update: I - (I>>>4) + spike*w, clamped to Q3.20.
  function automatic fix_t nxt(input fix_t i, input logic s, input fix_t w);
    logic signed [23:0] t;
    fix_t d;
    d = i >>> 4;
    t = {i[22], i} - {d[22], d};
    if (s) t = t + {w[22], w};
    if (t > 24'sh3F_FFFF) return 23'sh3F_FFFF;
    if (t < 24'shC0_0000) return 23'sh40_0000;
    return t[22:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    en_d = 1'b1; en_s = 1'b1; en_r = 1'b1; en_l = 1'b1;
    for (int k = 0; k < 5; k++) begin
      spk_d = 1'($urandom_range(0, 1));
      spk_s = 1'($urandom_range(0, 1));
      spk_r = 1'($urandom_range(0, 1));
      spk_l = 1'($urandom_range(0, 1));
      step();
    end
    vectors++; if ({i_d, i_s, i_r, i_l} !== '0) begin miscompares++;
      $display("FAIL reset_I I_out d=%h s=%h r=%h l=%h exp=0", i_d, i_s, i_r, i_l); end
    vectors++; if ({sat_d, sat_s, sat_r, sat_l} !== 4'b0) begin miscompares++;
      $display("FAIL reset_sat got=%b exp=0000", {sat_d, sat_s, sat_r, sat_l}); end
    vectors++; if ({rc_d, rc_s, rc_r, rc_l} !== '0) begin miscompares++;
      $display("FAIL reset_rate_count got=%h exp=0", {rc_d, rc_s, rc_r, rc_l}); end
    vectors++; if ({rv_d, rv_s, rv_r, rv_l} !== 4'b0) begin miscompares++;
      $display("FAIL reset_rate_valid got=%b exp=0000", {rv_d, rv_s, rv_r, rv_l}); end
    rst = 1'b1;
    en_d = 1'b0; en_s = 1'b0; en_r = 1'b0; en_l = 1'b0;
    spk_d = 1'b0; spk_s = 1'b0; spk_r = 1'b0; spk_l = 1'b0;
    step();
    step();
  endtask

  task automatic test_single_spike();
    fix_t e;
    en_d = 1'b1;
    step();  // IDLE->RUN edge, no update
    vectors++; if (i_d !== 23'sh0) begin miscompares++;
      $display("FAIL spike_enter I_out=%h exp=000000", i_d); end
    spk_d = 1'b1;
    step();
    spk_d = 1'b0;
    vectors++; if (i_d !== 23'sh02_0000) begin miscompares++;
      $display("FAIL spike_k1 I_out=%h exp=020000", i_d); end
    step();
    vectors++; if (i_d !== 23'sh01_E000) begin miscompares++;
      $display("FAIL spike_k2 I_out=%h exp=01e000", i_d); end
    step();
    vectors++; if (i_d !== 23'sh01_C200) begin miscompares++;
      $display("FAIL spike_k3 I_out=%h exp=01c200", i_d); end
    e = 23'sh01_C200;
    for (int k = 0; k < 12; k++) begin
      e = nxt(e, 1'b0, W_DEF);
      step();
      vectors++; if (i_d !== e || sat_d !== 1'b0 || rv_d !== 1'b0 || rc_d !== 8'd0) begin
        miscompares++;
        $display("FAIL spike_decay k=%0d I_out=%h sat=%b rv=%b rc=%0d exp I_out=%h sat=0 rv=0 rc=0",
                 k, i_d, sat_d, rv_d, rc_d, e); end
    end
  endtask

  task automatic test_saturation();
    en_s = 1'b1;
    step();
    spk_s = 1'b1;
    step();
    vectors++; if (i_s !== 23'sh20_0000 || sat_s !== 1'b0) begin miscompares++;
      $display("FAIL sat_k1 I_out=%h sat=%b exp=200000/0", i_s, sat_s); end
    step();
    vectors++; if (i_s !== 23'sh3E_0000 || sat_s !== 1'b0) begin miscompares++;
      $display("FAIL sat_k2 I_out=%h sat=%b exp=3e0000/0", i_s, sat_s); end
    step();
    vectors++; if (i_s !== 23'sh3F_FFFF || sat_s !== 1'b1) begin miscompares++;
      $display("FAIL sat_k3 I_out=%h sat=%b exp=3fffff/1", i_s, sat_s); end
    step();
    vectors++; if (i_s !== 23'sh3F_FFFF || sat_s !== 1'b1) begin miscompares++;
      $display("FAIL sat_k4 I_out=%h sat=%b exp=3fffff/1", i_s, sat_s); end
    spk_s = 1'b0;
    step();
    vectors++; if (i_s !== 23'sh3C_0000 || sat_s !== 1'b0) begin miscompares++;
      $display("FAIL sat_release I_out=%h sat=%b exp=3c0000/0", i_s, sat_s); end
  endtask

  task automatic test_rate_window();
    logic       erv;
    logic [7:0] erc;
    int         c;
    en_r = 1'b1;
    step();
    exp_r = '0;
    vectors++; if (i_r !== 23'sh0 || rv_r !== 1'b0) begin miscompares++;
      $display("FAIL rate_enter I_out=%h rv=%b exp=000000/0", i_r, rv_r); end
    for (int k = 1; k <= 32; k++) begin
      c = (k - 1) % 16;
      spk_r = (k <= 16) && (c == 1 || c == 4 || c == 7 || c == 10 || c == 15);
      exp_r = nxt(exp_r, spk_r, W_DEF);
      step();
      erv = RATE_ON && (k == 16 || k == 32);
      erc = (RATE_ON && k >= 16 && k < 32) ? 8'd5 : 8'd0;
      vectors++; if (i_r !== exp_r || rv_r !== erv || rc_r !== erc) begin miscompares++;
        $display("FAIL rate_win k=%0d I_out=%h rv=%b rc=%0d exp I_out=%h rv=%b rc=%0d",
                 k, i_r, rv_r, rc_r, exp_r, erv, erc); end
    end
    spk_r = 1'b0;
  endtask

  task automatic test_enable_drop();
    logic       erv;
    logic [7:0] erc;
    for (int k = 1; k <= 9; k++) begin
      spk_r = (k == 1);
      if (k == 9) en_r = 1'b0;
      exp_r = nxt(exp_r, spk_r, W_DEF);
      step();
      vectors++; if (i_r !== exp_r || rv_r !== 1'b0) begin miscompares++;
        $display("FAIL drop_pre k=%0d I_out=%h rv=%b exp I_out=%h rv=0", k, i_r, rv_r, exp_r); end
    end
    spk_r = 1'b0;
    for (int k = 0; k < 6; k++) begin
      spk_r = (k == 2);
      step();
      vectors++; if (i_r !== exp_r || rv_r !== 1'b0) begin miscompares++;
        $display("FAIL drop_idle k=%0d I_out=%h rv=%b exp I_out=%h rv=0", k, i_r, rv_r, exp_r); end
    end
    spk_r = 1'b0;
    en_r = 1'b1;
    step();
    vectors++; if (i_r !== exp_r || rv_r !== 1'b0) begin miscompares++;
      $display("FAIL drop_reenter I_out=%h rv=%b exp I_out=%h rv=0", i_r, rv_r, exp_r); end
    for (int k = 1; k <= 17; k++) begin
      spk_r = (k == 3);
      exp_r = nxt(exp_r, spk_r, W_DEF);
      step();
      erv = RATE_ON && (k == 16);
      erc = (RATE_ON && k >= 16) ? 8'd1 : 8'd0;
      vectors++; if (i_r !== exp_r || rv_r !== erv || rc_r !== erc) begin miscompares++;
        $display("FAIL drop_rewin k=%0d I_out=%h rv=%b rc=%0d exp I_out=%h rv=%b rc=%0d",
                 k, i_r, rv_r, rc_r, exp_r, erv, erc); end
    end
    spk_r = 1'b0;
  endtask

  task automatic test_long_window();
    logic       erv;
    logic [7:0] erc;
    en_l = 1'b1;
    step();
    for (int k = 1; k <= 321; k++) begin
      spk_l = (k <= 300);
      step();
      erv = RATE_ON && (k == 320);
      erc = (RATE_ON && k >= 320) ? 8'd255 : 8'd0;
      vectors++; if (rv_l !== erv || rc_l !== erc) begin miscompares++;
        $display("FAIL long_win k=%0d rv=%b rc=%0d exp rv=%b rc=%0d", k, rv_l, rc_l, erv, erc); end
    end
    spk_l = 1'b0;
  endtask

  task automatic test_async_reset();
    rst = 1'b0;
    #1;  // no clock edge between assertion and check
    vectors++; if ({i_d, i_s, i_r, i_l} !== '0) begin miscompares++;
      $display("FAIL async_I I_out d=%h s=%h r=%h l=%h exp=0", i_d, i_s, i_r, i_l); end
    vectors++; if ({rc_r, rc_l} !== 16'h0 || {rv_r, rv_l} !== 2'b0) begin miscompares++;
      $display("FAIL async_rate rc_r=%0d rc_l=%0d rv=%b%b exp 0/0/00", rc_r, rc_l, rv_r, rv_l); end
    vectors++; if ({sat_d, sat_s, sat_r, sat_l} !== 4'b0) begin miscompares++;
      $display("FAIL async_sat got=%b exp=0000", {sat_d, sat_s, sat_r, sat_l}); end
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_saturation();
    test_rate_window();
    test_enable_drop();
    test_long_window();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
